// File: rtl/ahbl_sram_slave_model.sv
// ahbl_sram_slave_model
//   Behavioural AHB-Lite memory slave. Accepts NONSEQ/SEQ transfers,
//   inserts a bench-chosen number of wait states, and can be told to
//   answer the next accepted transfer with a two-cycle ERROR response.
//   Addresses at or beyond DEPTH*W_DATA/8 always get an ERROR response.
//   Write data is committed on the clock edge that ends the data phase.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   src_hready_resp      slave HREADYOUT
//   src_hready           bus HREADY (tied to src_hready_resp when this is the only slave)
//   src_hresp            slave HRESP (1 = ERROR)
//   src_haddr/hwrite/htrans/hsize/hwdata   address/control and write data from master
//   src_hburst/hprot/hmastlock             accepted but not used
//   src_hrdata           read data, valid in the last data-phase cycle of a read
//   wait_cycles          wait states applied to the next accepted transfer
//   err_inject           force ERROR on the next accepted transfer
module ahbl_sram_slave_model #(
    parameter int unsigned W_ADDR = 32,
    parameter int unsigned W_DATA = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    output logic              src_hready_resp,
    input  logic              src_hready,
    output logic              src_hresp,
    input  logic [W_ADDR-1:0] src_haddr,
    input  logic              src_hwrite,
    input  logic [1:0]        src_htrans,
    input  logic [2:0]        src_hsize,
    input  logic [2:0]        src_hburst,
    input  logic [3:0]        src_hprot,
    input  logic              src_hmastlock,
    input  logic [W_DATA-1:0] src_hwdata,
    output logic [W_DATA-1:0] src_hrdata,
    input  logic [3:0]        wait_cycles,
    input  logic              err_inject
);

    localparam int unsigned     W_BYTES   = W_DATA / 8;
    localparam int unsigned     LANE_BITS = $clog2(W_BYTES);
    localparam int unsigned     IDX_BITS  = $clog2(DEPTH);
    localparam longint unsigned MEM_BYTES = 64'(DEPTH) * 64'(W_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_LAST,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [W_ADDR-1:0] addr_dph_q, addr_dph_d;
    logic              hwrite_dph_q, hwrite_dph_d;
    logic [2:0]        hsize_dph_q, hsize_dph_d;

    logic [W_DATA-1:0] mem [DEPTH];

    logic              take_new;
    logic              addr_err;
    logic [IDX_BITS-1:0] word_idx;
    logic [W_ADDR-1:0] lane_off;
    logic [W_ADDR-1:0] n_bytes;
    logic [W_BYTES-1:0] lane_en;
    logic              wr_commit;

    // Control inputs that carry no meaning for a flat memory.
    logic unused_ok;
    assign unused_ok = ^{src_hburst, src_hprot, src_hmastlock, src_htrans[0]};

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    always_comb begin
        // Only states that drive HREADYOUT high can end a data phase, so
        // only they may pick up a new address phase.
        take_new = src_hready && src_htrans[1] &&
                   (state_q == ST_IDLE || state_q == ST_LAST || state_q == ST_ERR2);
        addr_err = err_inject || (64'(src_haddr) >= MEM_BYTES);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_dph_d   = addr_dph_q;
        hwrite_dph_d = hwrite_dph_q;
        hsize_dph_d  = hsize_dph_q;

        case (state_q)
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_LAST;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                // IDLE, LAST and ERR2: either start the next data phase
                // immediately (no bubble) or fall back to IDLE.
                state_d = ST_IDLE;
                if (take_new) begin
                    addr_dph_d   = src_haddr;
                    hwrite_dph_d = src_hwrite;
                    hsize_dph_d  = src_hsize;
                    cnt_d        = wait_cycles;
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (wait_cycles == 4'd0) begin
                        state_d = ST_LAST;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_dph_q   <= '0;
            hwrite_dph_q <= 1'b0;
            hsize_dph_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_dph_q   <= addr_dph_d;
            hwrite_dph_q <= hwrite_dph_d;
            hsize_dph_q  <= hsize_dph_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory addressing and byte lanes
    // ------------------------------------------------------------------
    always_comb begin
        word_idx = IDX_BITS'(addr_dph_q >> LANE_BITS);
        lane_off = addr_dph_q & W_ADDR'(W_BYTES - 1);
        // Sizes wider than the bus saturate to a full-word write.
        if (hsize_dph_q >= 3'(LANE_BITS)) begin
            n_bytes = W_ADDR'(W_BYTES);
        end else begin
            n_bytes = W_ADDR'(1) << hsize_dph_q;
        end
        lane_en = '0;
        for (int unsigned i = 0; i < W_BYTES; i++) begin
            if (W_ADDR'(i) >= lane_off && W_ADDR'(i) < lane_off + n_bytes) begin
                lane_en[i] = 1'b1;
            end
        end
    end

    // A reset landing on the LAST edge drops the pending write.
    assign wr_commit = (state_q == ST_LAST) && hwrite_dph_q && !rst;

    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int unsigned i = 0; i < W_BYTES; i++) begin
                if (lane_en[i]) begin
                    mem[word_idx][8*i +: 8] <= src_hwdata[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response outputs, decoded from the state register
    // ------------------------------------------------------------------
    always_comb begin
        src_hready_resp = 1'b1;
        src_hresp       = 1'b0;
        src_hrdata      = '0;
        case (state_q)
            ST_WAIT: begin
                src_hready_resp = 1'b0;
            end
            ST_LAST: begin
                if (!hwrite_dph_q) begin
                    src_hrdata = mem[word_idx];
                end
            end
            ST_ERR1: begin
                src_hready_resp = 1'b0;
                src_hresp       = 1'b1;
            end
            ST_ERR2: begin
                src_hresp = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ahbl_sram_slave_model.sv
// Directed bench for ahbl_sram_slave_model (32-bit address/data, 1024 words).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ahbl_sram_slave_model;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] NSEQ = 2'b10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        src_hready_resp;
    logic        src_hready;
    logic        src_hresp;
    logic [31:0] src_haddr = '0;
    logic        src_hwrite = 1'b0;
    logic [1:0]  src_htrans = IDLE;
    logic [2:0]  src_hsize = 3'd2;
    logic [2:0]  src_hburst = '0;
    logic [3:0]  src_hprot = '0;
    logic        src_hmastlock = 1'b0;
    logic [31:0] src_hwdata = '0;
    logic [31:0] src_hrdata;
    logic [3:0]  wait_cycles = '0;
    logic        err_inject = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    assign src_hready = src_hready_resp;

    ahbl_sram_slave_model #(
        .W_ADDR(32),
        .W_DATA(32),
        .DEPTH (1024)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .src_hready_resp(src_hready_resp),
        .src_hready     (src_hready),
        .src_hresp      (src_hresp),
        .src_haddr      (src_haddr),
        .src_hwrite     (src_hwrite),
        .src_htrans     (src_htrans),
        .src_hsize      (src_hsize),
        .src_hburst     (src_hburst),
        .src_hprot      (src_hprot),
        .src_hmastlock  (src_hmastlock),
        .src_hwdata     (src_hwdata),
        .src_hrdata     (src_hrdata),
        .wait_cycles    (wait_cycles),
        .err_inject     (err_inject)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packs {hready_resp, hresp, hrdata} into one comparison.
    task automatic chk_bus(input string tag, input logic rdy, input logic resp, input logic [31:0] rdata);
        chk(tag, {30'b0, src_hready_resp, src_hresp, src_hrdata}, {30'b0, rdy, resp, rdata});
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic xfer(input logic [1:0] trans, input logic [31:0] addr, input logic wr,
                        input logic [2:0] size, input logic [3:0] wc, input logic ei);
        src_htrans  = trans;
        src_haddr   = addr;
        src_hwrite  = wr;
        src_hsize   = size;
        wait_cycles = wc;
        err_inject  = ei;
    endtask

    task automatic idle();
        xfer(IDLE, 32'h0, 1'b0, 3'd2, 4'd0, 1'b0);
    endtask

    initial begin
        idle();
        tick();
        tick();
        chk_bus("reset", 1'b1, 1'b0, 32'h0);
        rst = 1'b0;

        // Preload words 0x00 and 0x20
        xfer(NSEQ, 32'h00, 1'b1, 3'd2, 4'd0, 1'b0);
        tick();
        src_hwdata = 32'hCAFEF00D;
        xfer(NSEQ, 32'h20, 1'b1, 3'd2, 4'd0, 1'b0);
        tick();
        src_hwdata = 32'h0BADCAFE;
        idle();
        tick();
        chk_bus("preload_idle", 1'b1, 1'b0, 32'h0);

        // 1: zero-wait write then back-to-back read
        xfer(NSEQ, 32'h10, 1'b1, 3'd2, 4'd0, 1'b0);
        tick();
        chk_bus("t1_wr_dph", 1'b1, 1'b0, 32'h0);
        src_hwdata = 32'h12345678;
        xfer(NSEQ, 32'h10, 1'b0, 3'd2, 4'd0, 1'b0);
        tick();
        chk_bus("t1_rd_dph", 1'b1, 1'b0, 32'h12345678);
        idle();
        src_hwdata = '0;
        tick();
        chk_bus("t1_idle", 1'b1, 1'b0, 32'h0);

        // 2: three wait states, address changes during the stall ignored
        xfer(NSEQ, 32'h10, 1'b0, 3'd2, 4'd3, 1'b0);
        tick();
        xfer(NSEQ, 32'h20, 1'b1, 3'd0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk_bus($sformatf("t2_wait%0d", i), 1'b0, 1'b0, 32'h0);
            tick();
        end
        chk_bus("t2_last", 1'b1, 1'b0, 32'h12345678);
        idle();
        tick();
        chk_bus("t2_idle", 1'b1, 1'b0, 32'h0);

        // 3: byte and halfword writes only touch their lanes
        xfer(NSEQ, 32'h13, 1'b1, 3'd0, 4'd0, 1'b0);
        tick();
        src_hwdata = 32'hABFFFFFF;
        xfer(NSEQ, 32'h10, 1'b0, 3'd2, 4'd0, 1'b0);
        tick();
        chk_bus("t3_byte", 1'b1, 1'b0, 32'hAB345678);
        xfer(NSEQ, 32'h10, 1'b1, 3'd1, 4'd0, 1'b0);
        tick();
        src_hwdata = 32'h5555BEEF;
        xfer(NSEQ, 32'h10, 1'b0, 3'd2, 4'd0, 1'b0);
        tick();
        chk_bus("t3_half", 1'b1, 1'b0, 32'hAB34BEEF);
        idle();
        tick();

        // 4: out-of-range write and injected error, neither writes memory
        xfer(NSEQ, 32'h1000, 1'b1, 3'd2, 4'd5, 1'b0);
        tick();
        chk_bus("t4_oor_err1", 1'b0, 1'b1, 32'h0);
        src_hwdata = 32'hDEADBEEF;
        idle();
        tick();
        chk_bus("t4_oor_err2", 1'b1, 1'b1, 32'h0);
        tick();
        chk_bus("t4_oor_idle", 1'b1, 1'b0, 32'h0);
        xfer(NSEQ, 32'h10, 1'b1, 3'd2, 4'd0, 1'b1);
        tick();
        chk_bus("t4_inj_err1", 1'b0, 1'b1, 32'h0);
        idle();
        tick();
        chk_bus("t4_inj_err2", 1'b1, 1'b1, 32'h0);
        xfer(NSEQ, 32'h00, 1'b0, 3'd2, 4'd0, 1'b0);
        tick();
        chk_bus("t4_rd00", 1'b1, 1'b0, 32'hCAFEF00D);
        xfer(NSEQ, 32'h10, 1'b0, 3'd2, 4'd0, 1'b0);
        tick();
        chk_bus("t4_rd10", 1'b1, 1'b0, 32'hAB34BEEF);
        // Highest valid word is accepted normally
        xfer(NSEQ, 32'hFFC, 1'b1, 3'd2, 4'd0, 1'b0);
        tick();
        chk_bus("t4_top_wr", 1'b1, 1'b0, 32'h0);
        src_hwdata = 32'h600DF00D;
        xfer(NSEQ, 32'hFFC, 1'b0, 3'd2, 4'd0, 1'b0);
        tick();
        chk_bus("t4_top_rd", 1'b1, 1'b0, 32'h600DF00D);
        idle();
        tick();

        // 5: reset during the wait states of a write drops it
        xfer(NSEQ, 32'h20, 1'b1, 3'd2, 4'd5, 1'b0);
        tick();
        chk_bus("t5_wait", 1'b0, 1'b0, 32'h0);
        src_hwdata = 32'h11111111;
        idle();
        tick();
        rst = 1'b1;
        tick();
        chk_bus("t5_after_rst", 1'b1, 1'b0, 32'h0);
        rst = 1'b0;
        xfer(NSEQ, 32'h20, 1'b0, 3'd2, 4'd0, 1'b0);
        tick();
        chk_bus("t5_rd20", 1'b1, 1'b0, 32'h0BADCAFE);
        idle();
        tick();

        // 6: IDLE/BUSY never stall; new transfer taken straight out of ERR2
        xfer(IDLE, 32'h10, 1'b0, 3'd2, 4'd7, 1'b0);
        tick();
        chk_bus("t6_idle", 1'b1, 1'b0, 32'h0);
        xfer(BUSY, 32'h10, 1'b0, 3'd2, 4'd7, 1'b0);
        tick();
        chk_bus("t6_busy1", 1'b1, 1'b0, 32'h0);
        tick();
        chk_bus("t6_busy2", 1'b1, 1'b0, 32'h0);
        xfer(NSEQ, 32'h2000, 1'b0, 3'd2, 4'd0, 1'b0);
        tick();
        chk_bus("t6_err1", 1'b0, 1'b1, 32'h0);
        tick();
        chk_bus("t6_err2", 1'b1, 1'b1, 32'h0);
        xfer(NSEQ, 32'h10, 1'b0, 3'd2, 4'd2, 1'b0);
        tick();
        chk_bus("t6_b2b_wait1", 1'b0, 1'b0, 32'h0);
        idle();
        tick();
        chk_bus("t6_b2b_wait2", 1'b0, 1'b0, 32'h0);
        tick();
        chk_bus("t6_b2b_last", 1'b1, 1'b0, 32'hAB34BEEF);
        tick();
        chk_bus("t6_end", 1'b1, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahbl_sram_slave_model.md
Name: ahbl_sram_slave_model

Overview:
- Behavioural AHB-Lite memory slave with bench-controlled wait states and error injection.
- Sits directly downstream of the AHB-Lite master under test and consumes its requests.
- Used in simulation and formal harnesses alongside the master-side property checker, driving realistic stall and error responses into the master.
- Single slave: the bench ties src_hready to src_hready_resp.

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width; power of two, 8..64.
- DEPTH, 1024, memory size in W_DATA-wide words; decoded range is 0 to DEPTH*W_DATA/8-1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; synchronous, active-high.
- src_hready_resp  output  1  slave ready response.
- src_hready  input  1  bus HREADY.
- src_hresp  output  1  error response.
- src_haddr  input  W_ADDR  address.
- src_hwrite  input  1  write flag.
- src_htrans  input  2  transfer type.
- src_hsize  input  3  transfer size.
- src_hburst  input  3  burst type; ignored.
- src_hprot  input  4  protection; ignored.
- src_hmastlock  input  1  lock; ignored.
- src_hwdata  input  W_DATA  write data.
- src_hrdata  output  W_DATA  read data.
- wait_cycles  input  4  wait states for the next accepted transfer.
- err_inject  input  1  force ERROR response on the next accepted transfer.

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- Reset values: state=IDLE, src_hready_resp=1, src_hresp=0, src_hrdata=0, wait counter=0, all data-phase latches=0. Memory contents are not reset.
- Address-phase accept: on a clk edge where src_hready=1 and src_htrans[1]=1 (NSEQ/SEQ).
  - Latch haddr, hwrite, hsize.
  - Capture wait_cycles into cnt.
  - err = err_inject OR haddr >= DEPTH*W_DATA/8.
  - IDLE and BUSY get a zero-wait OKAY and are never accepted.
- Address is sampled only when src_hready=1. Values presented while stalled are ignored.
- States and the outputs they drive:
  - IDLE: hready_resp=1, hresp=0, hrdata=0.
  - WAIT: hready_resp=0, hresp=0, hrdata=0. cnt decrements each cycle. When cnt==1, go to LAST.
  - LAST: hready_resp=1, hresp=0. On a read, hrdata = mem[addr_dph word index] (combinational from the array); 0 on a write.
  - ERR1: hready_resp=0, hresp=1, hrdata=0. Always goes to ERR2.
  - ERR2: hready_resp=1, hresp=1, hrdata=0.
- Transitions on accept:
  - err=1 → ERR1, regardless of wait_cycles.
  - wait_cycles=0 → LAST.
  - otherwise → WAIT.
- Transitions out of LAST or ERR2:
  - If a new transfer is accepted on the same edge, follow the accept rules above (back-to-back, no bubble).
  - Otherwise go to IDLE.
- Data phase length: wait_cycles+1 cycles for OKAY; exactly 2 cycles for ERROR.
- Write commit:
  - Happens on the edge ending LAST, using the src_hwdata present in LAST.
  - Byte-lane enables come from hsize and the low address bits of addr_dph (little-endian; lane i covers bits 8i+7:8i).
  - Only lanes inside the transfer are written.
- ERROR transfers never write memory.
- Read-after-write back-to-back: a read whose data phase follows a write's LAST sees the written data.
- Reset mid-transfer (WAIT/ERR1/LAST): state goes to IDLE next cycle. An uncommitted write is dropped. Outputs return to reset values.
- No internal checking of alignment or hsize legality; the master-side checker owns that.
- Word index = addr_dph[log2(DEPTH)+log2(W_DATA/8)-1 : log2(W_DATA/8)].

Test Plan:
1. wait_cycles=0: write word 0x12345678 to 0x10, then NSEQ read 0x10 back-to-back → hready_resp=1 every cycle; hrdata=0x12345678 in the read data phase.
2. wait_cycles=3: read 0x10 → hready_resp=0 for 3 cycles, then 1 with hrdata=0x12345678. Address changes during the stall are ignored.
3. Byte write (hsize=0) of 0xAB at 0x13 over 0x12345678 → read of 0x10 returns 0xAB345678. Halfword write 0xBEEF at 0x10 → 0xAB34BEEF.
4. DEPTH=1024: write to 0x1000 → ERR1 (hready_resp=0, hresp=1), then ERR2 (1,1); a later read of 0x0 returns unchanged data. err_inject=1 on a valid address gives the same response and does not write.
5. rst asserted during WAIT of a write to 0x20 with wait_cycles=5 → next cycle hready_resp=1, hresp=0, hrdata=0; a later read of 0x20 shows the old value.
6. IDLE/BUSY with wait_cycles=7 → never stalls, hresp=0. A following NSEQ accepted in the same cycle that ERR2 completes starts its own data phase with no bubble.
